// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, status bit positions,
// exception cause codes and exception FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_DIV = 4'b1001;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam int ST_ZERO  = 7;
    localparam int ST_OV    = 6;
    localparam int ST_CARRY = 5;
    localparam int ST_NEG   = 4;
    localparam int ST_ODD   = 3;
    localparam int ST_DZ    = 2;

    localparam logic [7:0] ST_MASK = 8'hFC;

    localparam logic [3:0] CAUSE_OV = 4'hC;
    localparam logic [3:0] CAUSE_DZ = 4'hD;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_FLUSH   = 2'd2
    } exc_state_e;

    function automatic logic is_ov_op(input logic [3:0] ctrl);
        unique case (1'b1)
            ctrl == ALU_ADD: is_ov_op = 1'b1;
            ctrl == ALU_SUB: is_ov_op = 1'b1;
            ctrl == ALU_MUL: is_ov_op = 1'b1;
            default:         is_ov_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_exception_unit.sv
// EX-stage exception unit: registers ALU status, keeps sticky flags and
// raises precise overflow / divide-by-zero traps with a stall+flush handshake.
module alu_exception_unit
    import alu_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [7:0]       alu_status,
    input  logic [3:0]       alu_ctrl,
    input  logic             trap_en,
    input  logic [31:0]      pc_in,
    input  logic             exc_ack,
    input  logic             flag_clr,
    output logic [7:0]       flags_q,
    output logic [7:0]       sticky,
    output logic             exc_req,
    output logic [3:0]       exc_cause,
    output logic [31:0]      epc,
    output logic             stall,
    output logic             flush,
    output logic [CNT_W-1:0] exc_count
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    exc_state_e state_q;
    exc_state_e state_d;

    logic [3:0]  fcnt_q;
    logic [3:0]  fcnt_d;
    logic        accept;
    logic        dz;
    logic        ov;
    logic [7:0]  acc_flags;
    logic [7:0]  flags_d;
    logic [7:0]  sticky_d;
    logic        req_d;
    logic        stall_d;
    logic        flush_d;
    logic [3:0]  cause_d;
    logic [31:0] epc_d;
    logic        raise;

    // stall is registered, so accept never depends combinationally on outputs
    assign accept    = valid_in & ~stall;
    assign acc_flags = alu_status & ST_MASK;
    assign dz        = alu_status[ST_DZ] && (alu_ctrl == ALU_DIV);
    assign ov        = alu_status[ST_OV] && trap_en && is_ov_op(alu_ctrl);

    always_comb begin
        flags_d  = flags_q;
        sticky_d = sticky;
        if (accept) begin
            flags_d  = acc_flags;
            sticky_d = (flag_clr ? 8'h00 : sticky) | acc_flags;
        end else if (flag_clr) begin
            sticky_d = 8'h00;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        req_d   = exc_req;
        stall_d = stall;
        flush_d = flush;
        cause_d = exc_cause;
        epc_d   = epc;
        raise   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept && (dz || ov)) begin
                    state_d = S_PENDING;
                    req_d   = 1'b1;
                    stall_d = 1'b1;
                    epc_d   = pc_in;
                    cause_d = dz ? CAUSE_DZ : CAUSE_OV;
                    raise   = 1'b1;
                end
            end
            S_PENDING: begin
                if (exc_ack) begin
                    state_d = S_FLUSH;
                    req_d   = 1'b0;
                    flush_d = 1'b1;
                    fcnt_d  = FLUSH_LOAD;
                end
            end
            S_FLUSH: begin
                if (fcnt_q == 4'd0) begin
                    state_d = S_IDLE;
                    flush_d = 1'b0;
                    stall_d = 1'b0;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                stall_d = 1'b0;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            fcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q   <= 8'h00;
            sticky    <= 8'h00;
            exc_req   <= 1'b0;
            exc_cause <= 4'h0;
            epc       <= 32'h0;
            stall     <= 1'b0;
            flush     <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            sticky    <= sticky_d;
            exc_req   <= req_d;
            exc_cause <= cause_d;
            epc       <= epc_d;
            stall     <= stall_d;
            flush     <= flush_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_exc_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (raise),
        .count(exc_count)
    );

endmodule

// File: doc/alu_exception_unit.md
Name: alu_exception_unit

Overview:
- Sits directly downstream of the ALU in the EX stage.
- On each completing instruction it registers the ALU's 8-bit status word and accumulates sticky flags.
- It raises a precise exception request to the control unit on a trapping overflow or a divide-by-zero, capturing EPC and cause.
- It stalls and then flushes the pipeline through a request/acknowledge handshake.

Parameters:
- FLUSH_CYCLES, 2, cycles flush is held high after exc_ack (legal range 1..15)
- CNT_W, 16, width of the saturating exception counter

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  reset, synchronous and active-high
- valid_in  input  1  an EX-stage instruction completes this cycle; alu_status and pc_in are valid
- alu_status  input  8  [7] zero, [6] overflow, [5] carry, [4] negative, [3] odd, [2] divide-by-zero, [1:0] reserved
- alu_ctrl  input  4  ALU operation code of the completing instruction
- trap_en  input  1  instruction traps on overflow (add/sub); 0 for unsigned forms
- pc_in  input  32  PC of the completing instruction
- exc_ack  input  1  control unit accepts the pending exception
- flag_clr  input  1  clear sticky flags
- flags_q  output  8  status of last accepted instruction
- sticky  output  8  OR of statuses accepted since reset or last flag_clr
- exc_req  output  1  exception pending
- exc_cause  output  4  cause code of pending/last exception
- epc  output  32  PC of faulting instruction
- stall  output  1  upstream must hold; valid_in ignored while high
- flush  output  1  squash younger instructions
- exc_count  output  CNT_W  number of exceptions raised, saturating

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): all outputs 0, FSM to IDLE. This applies from any state, including mid-PENDING or mid-FLUSH.
- Accept condition: valid_in=1 and stall=0. On accept, next edge: flags_q <= {alu_status[7:2],2'b00}.
- Sticky update:
  - On accept: sticky <= sticky | accepted flags.
  - flag_clr without accept: sticky <= 0.
  - flag_clr with accept in the same cycle: sticky <= accepted flags only.
- Trap conditions, evaluated on accept:
  - dz = alu_status[2] and alu_ctrl==DIV (4'b1001).
  - ov = alu_status[6] and trap_en and alu_ctrl in {ADD 4'b0010, SUB 4'b0110, MUL 4'b1000}.
  - dz has priority over ov.
- FSM states: IDLE, PENDING, FLUSH.
  - IDLE: accept with dz or ov -> PENDING next edge. At that edge: exc_req<=1, stall<=1, epc<=pc_in, exc_cause<=CAUSE_DZ (4'hD) or CAUSE_OV (4'hC), exc_count increments (saturates at all-ones). Latency from trapping instruction to exc_req is 1 cycle.
  - PENDING: exc_req=1, stall=1. exc_ack=1 -> FLUSH next edge, with exc_req<=0, flush<=1, and the flush counter loaded with FLUSH_CYCLES-1.
  - FLUSH: stall=1, flush=1. The counter decrements each cycle; at 0 -> IDLE next edge, with flush<=0 and stall<=0. flush is therefore high for exactly FLUSH_CYCLES cycles.
- exc_ack outside PENDING is ignored.
- epc and exc_cause hold their value until the next exception. They are not cleared by leaving FLUSH.
- valid_in while stall=1 is ignored: no flag, sticky or trap update. The instruction following a trap is therefore never accepted before the flush.
- Non-trapping overflow (trap_en=0) updates flags and sticky only.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package alu_pkg:
  - ALU control codes (AND, OR, ADD, SUB, SLT, NOR, XOR, MUL, DIV)
  - status bit indices (ST_ZERO=7 … ST_DZ=2)
  - cause codes CAUSE_OV, CAUSE_DZ
  - FSM state encoding
- One natural sub-module, sat_counter: a parameterised saturating incrementer with synchronous reset, used for exc_count.

Test Plan:
- Reset then non-trapping ADD (status 8'h80, valid_in=1): flags_q=8'h80, sticky=8'h80, exc_req stays 0.
- ADD with status 8'h40, trap_en=1, pc_in=32'h0040_0010: next cycle exc_req=1, stall=1, epc=32'h0040_0010, exc_cause=4'hC, exc_count=1. Ack 3 cycles later: flush high exactly 2 cycles, then stall=0.
- DIV with status 8'h84 and trap_en=1: exc_cause=4'hD. A valid_in with status 8'h10 during PENDING: sticky unchanged (still 8'h84).
- flag_clr with simultaneous accept of status 8'h10 while sticky=8'hC0: sticky becomes 8'h10.
- rst asserted during FLUSH: next edge all outputs 0, state IDLE. A trapping ADD immediately after raises exc_req again one cycle later.
- Force 2^16+3 traps with CNT_W=16: exc_count holds 16'hFFFF.
